cpu_step_ctrl: RTL

Sequencing controller that drives the single-cycle CPU on the Basys3 board from the 100 MHz board clock. The CPU no longer takes its clock from a raw button; it receives a one-cycle clock-enable pulse from this block. Pulses come from a debounced `next_button` press (single-step), from a free-running divider (run mode), or stop at a PC breakpoint. The block also reports its state and a step counter for the 7-segment display path.

---
 rtl/cpu_step_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: debounced single-step / run / breakpoint clock-enable sequencer for the CPU
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV = 10_000_000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        next_button,
  input  logic        run_sw,
  input  logic        bp_en_sw,
  input  logic [7:0]  bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_step,
  output logic [1:0]  state,
  output logic [15:0] step_count,
  output logic        btn_db
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(RUN_DIV);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, BRK = 2'b10} st_t;
  st_t st, st_n;
  logic sync1, btn_s, btn_db_d, press, step_n, run_step, run_step_n, chk, bp_hit, div_tc;
  logic [DW-1:0] deb_cnt;
  logic [VW-1:0] div, div_n;
  logic pc_unused;
  assign pc_unused = &{1'b0, pc[31:8]};
  assign press = btn_db & ~btn_db_d;
  assign bp_hit = chk & bp_en_sw & (pc[7:0] == bp_addr);
  assign div_tc = div == VW'(RUN_DIV - 1);
  assign state = st;
  // two-flop synchronizer, then accept a level change only after it has held long enough
  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
      btn_db <= 1'b0;
      btn_db_d <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= next_button;
      btn_s <= sync1;
      btn_db_d <= btn_db;
      if (btn_s == btn_db) deb_cnt <= '0;
      else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= ~btn_db;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  end
  // mode next-state; divider clears whenever it is not explicitly advanced
  always_comb begin
    st_n = st;
    step_n = 1'b0;
    run_step_n = 1'b0;
    div_n = '0;
    case (st)
      HALT: if (press) begin
        st_n = run_sw ? RUN : HALT;
        step_n = ~run_sw;
      end
      RUN: if (press || !run_sw) st_n = HALT;
      else if (bp_hit) st_n = BRK;
      else if (div_tc) begin
        step_n = 1'b1;
        run_step_n = 1'b1;
      end else div_n = div + 1'b1;
      BRK: if (press) begin
        step_n = 1'b1;
        st_n = run_sw ? RUN : HALT;
      end else if (!run_sw) st_n = HALT;
      default: st_n = HALT;
    endcase
  end
  // state, divider, step pulse and the one-cycle-late breakpoint check window
  always_ff @(posedge clk) begin
    if (Reset) begin
      st <= HALT;
      div <= '0;
      cpu_step <= 1'b0;
      run_step <= 1'b0;
      chk <= 1'b0;
      step_count <= '0;
    end else begin
      st <= st_n;
      div <= div_n;
      cpu_step <= step_n;
      run_step <= run_step_n;
      chk <= run_step;
      step_count <= step_count + {15'd0, step_n};
    end
  end
endmodule
